// File: rtl/wb_bcd_display_slave.sv
// ---------------------------------------------------------------------------
// wb_bcd_display_slave
// Wishbone slave driving a 4-digit multiplexed 7-segment display. A binary
// VALUE is converted to BCD by a serial shift-add-3 engine and committed to
// the displayed digits atomically; a prescaler steps the digit scan.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   addr_i, data_i        Wishbone byte address, write data
//   data_o                read data (0 whenever ack_o is low)
//   sel_i                 byte-lane selects (lanes 0 and 1 used)
//   stb_i, cyc_i, we_i    Wishbone strobe, cycle, write enable
//   ack_o                 single-cycle registered acknowledge
//   an                    active-low digit enables, an[0] = least-significant digit
//   hex_display           active-low segments, bit0 = a .. bit6 = g, bit7 = dp
//
// Register map (addr_i[3:2])
//   0 VALUE[15:0] R/W   1 CTRL[2:0] R/W (enable, blank, dp2)
//   2 STATUS RO (bit0 busy, bit1 overflow)   3 reads 0
//
// Conversion FSM
//   state    | meaning
//   S_IDLE   | no conversion in progress
//   S_LOAD   | capture VALUE into the shift register
//   S_SHIFT  | 16 shift-add-3 steps
//   S_COMMIT | copy BCD result (or 9999 on overflow) to the display
// ---------------------------------------------------------------------------
module wb_bcd_display_slave #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 11,
    parameter int CLK_FREQ      = 5000000,
    parameter int SCAN_FREQ     = 1000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [WB_DATA_WIDTH-1:0]   data_i,
    output logic [WB_DATA_WIDTH-1:0]   data_o,
    input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
    input  logic                       stb_i,
    input  logic                       cyc_i,
    input  logic                       we_i,
    output logic                       ack_o,
    output logic [3:0]                 an,
    output logic [7:0]                 hex_display
);

    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int DIV   = CLK_FREQ / SCAN_FREQ;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

    state_t      state, state_nx;
    logic [15:0] value;
    logic [2:0]  ctrl;
    logic        start_q;
    logic        busy;
    logic        overflow;
    logic [15:0] digits;
    logic [15:0] conv_val;
    logic [15:0] sh_bin;
    logic [19:0] sh_bcd;
    logic [19:0] bcd_adj;
    logic [3:0]  bit_cnt;
    logic [PW-1:0] presc;
    logic [1:0]  digit_idx;

    logic        take;
    logic [1:0]  reg_sel;
    logic [WB_DATA_WIDTH-1:0] rd_data;

    logic unused_inputs;
    assign unused_inputs = ^{data_i[WB_DATA_WIDTH-1:16], addr_i[WB_ADDR_WIDTH-1:4],
                             addr_i[1:0], sel_i[SEL_W-1:2]};

    // A request held across cycles is taken only while ack_o is low, which
    // yields one ack every two cycles for back-to-back strobes.
    assign take    = stb_i & cyc_i & ~ack_o;
    assign reg_sel = addr_i[3:2];
    assign busy    = (state != S_IDLE);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data[15:0] = value;
            2'd1:    rd_data[2:0]  = ctrl;
            2'd2:    rd_data[1:0]  = {overflow, busy};
            default: rd_data       = '0;
        endcase
    end

    // Bus side: ack, read data, register writes, conversion start pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            data_o  <= '0;
            value   <= '0;
            ctrl    <= '0;
            start_q <= 1'b0;
        end else begin
            ack_o   <= take;
            data_o  <= '0;
            start_q <= 1'b0;
            if (take) begin
                data_o <= rd_data;
                if (we_i) begin
                    case (reg_sel)
                        2'd0: begin
                            if (sel_i[0]) value[7:0]  <= data_i[7:0];
                            if (sel_i[1]) value[15:8] <= data_i[15:8];
                            start_q <= sel_i[0] | sel_i[1];
                        end
                        2'd1: begin
                            if (sel_i[0]) ctrl <= data_i[2:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_IDLE;
            S_LOAD:   state_nx = S_SHIFT;
            S_SHIFT:  if (bit_cnt == 4'd15) state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // A new VALUE write always restarts from LOAD, aborting any run.
        if (start_q) state_nx = S_LOAD;
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) begin
            bcd_adj[i*4 +: 4] = (sh_bcd[i*4 +: 4] >= 4'd5) ? sh_bcd[i*4 +: 4] + 4'd3
                                                          : sh_bcd[i*4 +: 4];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_bin   <= '0;
            sh_bcd   <= '0;
            bit_cnt  <= '0;
            conv_val <= '0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    sh_bin   <= value;
                    sh_bcd   <= '0;
                    bit_cnt  <= '0;
                    conv_val <= value;
                end
                S_SHIFT: begin
                    sh_bcd  <= {bcd_adj[18:0], sh_bin[15]};
                    sh_bin  <= {sh_bin[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                S_COMMIT: begin
                    if (conv_val > 16'd9999) begin
                        digits   <= 16'h9999;
                        overflow <= 1'b1;
                    end else begin
                        digits   <= sh_bcd[15:0];
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (presc == PRESC_MAX) begin
            presc     <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [3:0] cur_digit;
    logic       blank;
    logic [6:0] seg_nx;
    logic       dp_nx;

    always_comb begin
        cur_digit = digits[{digit_idx, 2'b00} +: 4];
        blank     = 1'b0;
        case (digit_idx)
            2'd3: blank = (digits[15:12] == 4'd0);
            2'd2: blank = (digits[15:8]  == 8'd0);
            2'd1: blank = (digits[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        blank  = blank & ctrl[1];
        seg_nx = blank ? 7'h7F : seg7(cur_digit);
        dp_nx  = ~(ctrl[2] && (digit_idx == 2'd2));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an          <= 4'hF;
            hex_display <= 8'hFF;
        end else if (ctrl[0]) begin
            an          <= ~(4'b0001 << digit_idx);
            hex_display <= {dp_nx, seg_nx};
        end else begin
            an          <= 4'hF;
            hex_display <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_wb_bcd_display_slave.sv
// ---------------------------------------------------------------------------
// Testbench for wb_bcd_display_slave. Bus reads push their expected data into
// a queue and compare on ack; scan checks push the expected {an, hex} per
// digit and compare as each digit appears.
// ---------------------------------------------------------------------------
module tb_wb_bcd_display_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [3:0]  sel_i = '0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        we_i  = 1'b0;
    logic        ack_o;
    logic [3:0]  an;
    logic [7:0]  hex_display;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_q[$];
    logic [11:0] scan_q[$];

    logic mon_en  = 1'b0;
    logic saw_100 = 1'b0;

    always #5 clk_i = ~clk_i;

    wb_bcd_display_slave #(
        .WB_DATA_WIDTH(32),
        .WB_ADDR_WIDTH(11),
        .CLK_FREQ(1000),
        .SCAN_FREQ(100)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .addr_i(addr_i),
        .data_i(data_i),
        .data_o(data_o),
        .sel_i(sel_i),
        .stb_i(stb_i),
        .cyc_i(cyc_i),
        .we_i(we_i),
        .ack_o(ack_o),
        .an(an),
        .hex_display(hex_display)
    );

    // Digit 2 showing "1" would mean the aborted value 100 was committed.
    always @(negedge clk_i) begin
        if (mon_en && an == 4'b1011 && hex_display[6:0] == 7'h79) saw_100 = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return {1'b1, s};
    endfunction

    task automatic wb_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk_i);
        addr_i = a; data_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i); #1; n++;
        end while (!ack_o && n < 20);
        check_val("wr_ack", {31'd0, ack_o}, 32'd1);
        @(negedge clk_i);
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        rd_q.push_back(exp);
        @(negedge clk_i);
        addr_i = a; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i); #1; n++;
        end while (!ack_o && n < 20);
        e = rd_q.pop_front();
        if (!ack_o) check_val({tag, "_ack_timeout"}, {31'd0, ack_o}, 32'd1);
        else        check_val(tag, data_o, e);
        @(negedge clk_i);
        stb_i = 1'b0; cyc_i = 1'b0;
        @(posedge clk_i); #1;
        check_val({tag, "_ack_single"}, {31'd0, ack_o}, 32'd0);
        check_val({tag, "_data_idle"}, data_o, 32'd0);
    endtask

    task automatic count_busy(input string tag, input int exp);
        int c;
        c = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i); #1;
            if (dut.busy) c++;
            else break;
        end
        check_val(tag, c, exp);
    endtask

    task automatic check_scan(input string tag, input logic [7:0] h0, input logic [7:0] h1,
                              input logic [7:0] h2, input logic [7:0] h3);
        logic [7:0]  hv[4];
        logic [3:0]  one;
        logic [3:0]  prev;
        logic [11:0] e;
        int n;
        hv  = '{h0, h1, h2, h3};
        one = 4'b0001;
        n = 0;
        while (an !== 4'b1110 && n < 200) begin
            @(negedge clk_i); n++;
        end
        if (an !== 4'b1110) begin
            check_val({tag, "_sync"}, {28'd0, an}, 32'hE);
            return;
        end
        for (int k = 0; k < 4; k++) scan_q.push_back({~(one << k), hv[k]});
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                prev = an;
                n = 0;
                while (an === prev && n < 50) begin
                    @(negedge clk_i); n++;
                end
            end
            e = scan_q.pop_front();
            check_val($sformatf("%s_d%0d", tag, k), {20'd0, an, hex_display}, {20'd0, e});
        end
    endtask

    initial begin
        int acks;
        int bad;

        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_an",   {28'd0, an}, 32'hF);
        check_val("rst_hex",  {24'd0, hex_display}, 32'hFF);
        check_val("rst_ack",  {31'd0, ack_o}, 32'd0);
        check_val("rst_data", data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        wb_read("rd_value0",  11'h0, 32'd0);
        wb_read("rd_ctrl0",   11'h4, 32'd0);
        wb_read("rd_status0", 11'h8, 32'd0);

        // 1234 with display enabled
        wb_write(11'h4, 32'd1, 4'hF);
        wb_write(11'h0, 32'd1234, 4'h3);
        count_busy("busy_1234", 18);
        wb_read("status_1234", 11'h8, 32'd0);
        wb_read("value_1234",  11'h0, 32'd1234);
        check_scan("scan_1234", hx(4), hx(3), hx(2), hx(1));

        // overflow saturates to 9999
        wb_write(11'h0, 32'd12345, 4'h3);
        count_busy("busy_12345", 18);
        wb_read("status_ovf", 11'h8, 32'h2);
        check_scan("scan_9999", hx(9), hx(9), hx(9), hx(9));

        // leading-zero blanking
        wb_write(11'h4, 32'd3, 4'h1);
        wb_write(11'h0, 32'd7, 4'h3);
        count_busy("busy_7", 18);
        wb_read("status_7", 11'h8, 32'd0);
        check_scan("scan_blank7", hx(7), 8'hFF, 8'hFF, 8'hFF);

        // abort: 100 superseded by 42, dp on digit 2
        wb_write(11'h4, 32'd5, 4'h1);
        saw_100 = 1'b0;
        mon_en  = 1'b1;
        wb_write(11'h0, 32'd100, 4'h3);
        repeat (5) @(posedge clk_i);
        wb_write(11'h0, 32'd42, 4'h3);
        count_busy("busy_abort", 18);
        check_scan("scan_42dp", hx(2), hx(4), hx(0) & 8'h7F, hx(0));
        mon_en = 1'b0;
        check_val("never_100", {31'd0, saw_100}, 32'd0);

        // byte lanes and unmapped address
        wb_write(11'h0, 32'h0000ABCD, 4'b0001);
        wb_read("value_lane0", 11'h0, 32'h000000CD);
        wb_read("rd_addr_c",   11'hC, 32'd0);
        wb_write(11'hC, 32'hFFFFFFFF, 4'hF);
        wb_read("rd_addr_c2",  11'hC, 32'd0);
        wb_read("ctrl_kept",   11'h4, 32'd5);
        repeat (25) @(posedge clk_i);
        wb_write(11'h0, 32'h11111111, 4'b1100);
        count_busy("busy_upper_lanes", 0);
        wb_read("value_upper_lanes", 11'h0, 32'h000000CD);

        // held strobe: one ack per two cycles
        @(negedge clk_i);
        addr_i = 11'h4; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin
                acks++;
                check_val("b2b_data", data_o, 32'd5);
            end
        end
        @(negedge clk_i);
        stb_i = 1'b0; cyc_i = 1'b0;
        check_val("b2b_acks", acks, 3);

        // reset mid-conversion
        wb_write(11'h0, 32'd999, 4'h3);
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check_val("midrst_an",   {28'd0, an}, 32'hF);
        check_val("midrst_hex",  {24'd0, hex_display}, 32'hFF);
        check_val("midrst_ack",  {31'd0, ack_o}, 32'd0);
        check_val("midrst_data", data_o, 32'd0);
        check_val("midrst_busy", {31'd0, dut.busy}, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
            if (ack_o || dut.busy) bad++;
        end
        check_val("postrst_quiet", bad, 0);
        wb_read("postrst_value",  11'h0, 32'd0);
        wb_read("postrst_ctrl",   11'h4, 32'd0);
        wb_read("postrst_status", 11'h8, 32'd0);
        wb_write(11'h4, 32'd1, 4'h1);
        check_scan("scan_postrst", hx(0), hx(0), hx(0), hx(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bcd_display_slave.md
WB_BCD_DISPLAY_SLAVE -- requirements
Module: wb_bcd_display_slave

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 11, Wishbone address width.
REQ-003 SHALL have parameter CLK_FREQ, default 5000000, clk_i frequency in Hz.
REQ-004 SHALL have parameter SCAN_FREQ, default 1000, digit-advance rate in Hz.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port addr_i, input, WB_ADDR_WIDTH, byte address.
REQ-008 SHALL have port data_i, input, WB_DATA_WIDTH, write data.
REQ-009 SHALL have port data_o, output, WB_DATA_WIDTH, read data.
REQ-010 SHALL have port sel_i, input, WB_DATA_WIDTH/8, byte-lane selects.
REQ-011 SHALL have ports stb_i, cyc_i and we_i, each input, 1, Wishbone strobe, cycle and write enable.
REQ-012 SHALL have port ack_o, output, 1, Wishbone acknowledge.
REQ-013 SHALL have port an, output, 4, active-low digit enables, an[0] = least-significant digit.
REQ-014 SHALL have port hex_display, output, 8, active-low segments: bit0 = a through bit6 = g, bit7 = dp.

Function
REQ-015 SHALL decode the register map on addr_i[3:2]:
- 0: VALUE[15:0], R/W, binary count.
- 1: CTRL, R/W; bit0 = enable, bit1 = blank leading zeros, bit2 = dp on digit 2.
- 2: STATUS, RO; bit0 = busy, bit1 = overflow.
- 3: reads 0, writes ignored.
REQ-016 SHALL acknowledge with ack_o high for exactly one cycle, registered, the cycle after stb_i & cyc_i are seen with ack_o low.
REQ-017 SHALL give back-to-back requests one ack per two cycles; no request is ever left unacknowledged.
REQ-018 SHALL apply a write on the acking edge and honour sel_i byte lanes: sel_i[0] for bits [7:0], sel_i[1] for bits [15:8]; upper lanes are ignored.
REQ-019 SHALL hold data_o valid while ack_o is high, zero-extend unused bits, and drive 0 when ack_o is low.
REQ-020 SHALL start a binary-to-BCD conversion (shift-add-3) on any VALUE write with at least one of sel_i[1:0] set.
REQ-021 SHALL run the conversion FSM as IDLE -> LOAD (1 cycle) -> SHIFT (16 cycles) -> COMMIT (1 cycle) -> IDLE, so busy is high for 18 cycles starting the cycle after the ack.
REQ-022 SHALL, on a VALUE write while busy, abort the current conversion and restart at LOAD with the new value; the display keeps its previous digits until a COMMIT.
REQ-023 SHALL, at COMMIT, update the displayed digits atomically: if VALUE > 9999, digits = 9,9,9,9 and overflow = 1; otherwise the BCD digits and overflow = 0.
REQ-024 SHALL drive the scan with a prescaler counting 0..CLK_FREQ/SCAN_FREQ-1, advancing the digit index 0->1->2->3->0 on terminal count.
REQ-025 SHALL make exactly one an bit low when CTRL.enable = 1, and hold an = 4'b1111 and hex_display = 8'hFF when enable = 0.
REQ-026 SHALL decode digits 0-9 to standard segments and any BCD code above 9 to all segments off.
REQ-027 SHALL, with CTRL.bit1 = 1, blank (segments 7'h7F) leading-zero digits 3..1; digit 0 is never blanked.
REQ-028 SHALL drive dp (bit7) low only on digit 2 when CTRL.bit2 = 1.
REQ-029 SHALL register an and hex_display, giving one cycle of latency from the index change.

Reset
REQ-030 SHALL, on rst_i high, asynchronously clear VALUE, CTRL, the displayed digits, overflow, FSM (to IDLE), prescaler and digit index, drive ack_o = 0, data_o = 0, an = 4'b1111, hex_display = 8'hFF, and abort any bus cycle or conversion in progress with no ack.

Verification
REQ-031 SHALL pass: reset, write CTRL = 1 and VALUE = 1234 -> busy for 18 cycles, then digits 1,2,3,4 scanned with an = 1110, 1101, 1011, 0111 sequence.
REQ-032 SHALL pass: write VALUE = 12345 -> STATUS reads 0x2 after COMMIT, display shows 9999.
REQ-033 SHALL pass: CTRL = 3, VALUE = 7 -> digits 3..1 all segments off, digit 0 shows "7".
REQ-034 SHALL pass: write VALUE = 100 then VALUE = 42 five cycles later -> display never shows 100, ends at 0042, busy for 18 cycles after the second ack.
REQ-035 SHALL pass: write VALUE = 16'hABCD with sel = 4'b0001 -> VALUE reads 0x00CD; reading address 0xC returns 0 with a single ack.
REQ-036 SHALL pass: assert rst_i mid-conversion -> all outputs at reset values immediately, with no ack and no COMMIT afterwards.
